spi_serf: RTL and testbench

SPI_SERF -- requirements
Module: spi_serf

---
 rtl/spi_serf.sv | 127 ++++++++++++
 tb/tb_spi_serf.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/spi_serf.sv
// SPI serf: receives 16-bit commands from the monarch and shifts out a preloaded response word.
// All SPI pins are resynchronized into clk_sys-style single-clock logic; edges come from 3-flop chains.
module spi_serf (
   input  logic        clk,
   input  logic        rst,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   input  logic        wrt,
   input  logic [15:0] tx_data,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   output logic        frm_err
);

   // state | meaning
   // IDLE  | SS_n high (or not yet seen falling), MISO held low
   // SHIFT | frame in progress, counting SCLK rises up to 16
   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [2:0]  ss_sync_q, sclk_sync_q;
   logic [1:0]  mosi_sync_q;
   logic [1:0]  settle_q;
   logic [15:0] tx_buf_q;
   logic [15:0] tx_shft_q, tx_shft_d;
   logic [15:0] rx_shft_q, rx_shft_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [15:0] cmd_q, cmd_d;
   logic        cmd_rdy_q, cmd_rdy_d;
   logic        frm_err_q, frm_err_d;

   logic sclk_rise, sclk_fall, ss_fall, ss_rise, mosi_s;

   // settle_q masks the artificial SS_n fall seen while the chain refills after reset
   assign ss_fall   = ~ss_sync_q[1] &  ss_sync_q[2] & (settle_q == 2'd0);
   assign ss_rise   =  ss_sync_q[1] & ~ss_sync_q[2];
   assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];
   assign mosi_s    =  mosi_sync_q[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         ss_sync_q   <= 3'b111;
         sclk_sync_q <= 3'b000;
         mosi_sync_q <= 2'b00;
         settle_q    <= 2'd3;
      end else begin
         ss_sync_q   <= {ss_sync_q[1:0], SS_n};
         sclk_sync_q <= {sclk_sync_q[1:0], SCLK};
         mosi_sync_q <= {mosi_sync_q[0], MOSI};
         if (settle_q != 2'd0)
            settle_q <= settle_q - 2'd1;
      end
   end

   always_comb begin
      state_d   = state_q;
      tx_shft_d = tx_shft_q;
      rx_shft_d = rx_shft_q;
      bit_cnt_d = bit_cnt_q;
      cmd_d     = cmd_q;
      frm_err_d = 1'b0;
      cmd_rdy_d = cmd_rdy_q & ~clr_cmd_rdy & ~ss_fall;
      case (state_q)
         IDLE: begin
            if (ss_fall) begin
               state_d   = SHIFT;
               tx_shft_d = tx_buf_q;
               rx_shft_d = 16'h0000;
               bit_cnt_d = 5'd0;
            end
         end
         SHIFT: begin
            if (ss_rise) begin
               state_d = IDLE;
               if (bit_cnt_q == 5'd16) begin
                  cmd_d     = rx_shft_q;
                  cmd_rdy_d = 1'b1;
               end else begin
                  frm_err_d = 1'b1;
               end
            end else begin
               if (sclk_rise && (bit_cnt_q < 5'd16)) begin
                  rx_shft_d = {rx_shft_q[14:0], mosi_s};
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
               // the leading fall before the first rise must not consume bit 15
               if (sclk_fall && (bit_cnt_q != 5'd0) && (bit_cnt_q < 5'd16))
                  tx_shft_d = {tx_shft_q[14:0], 1'b0};
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         tx_buf_q  <= 16'h0000;
         tx_shft_q <= 16'h0000;
         rx_shft_q <= 16'h0000;
         bit_cnt_q <= 5'd0;
         cmd_q     <= 16'h0000;
         cmd_rdy_q <= 1'b0;
         frm_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         if (wrt)
            tx_buf_q <= tx_data;
         tx_shft_q <= tx_shft_d;
         rx_shft_q <= rx_shft_d;
         bit_cnt_q <= bit_cnt_d;
         cmd_q     <= cmd_d;
         cmd_rdy_q <= cmd_rdy_d;
         frm_err_q <= frm_err_d;
      end
   end

   assign MISO    = (state_q == SHIFT) & tx_shft_q[15];
   assign cmd     = cmd_q;
   assign cmd_rdy = cmd_rdy_q;
   assign frm_err = frm_err_q;

endmodule

// File: tb/tb_spi_serf.sv
// Bench for spi_serf: a bit-banged SPI monarch (half-period 16 clk) against a word-level reference model.
module tb_spi_serf;

   logic        clk = 1'b0;
   logic        rst, SS_n, SCLK, MOSI, wrt, clr_cmd_rdy;
   logic [15:0] tx_data;
   logic        MISO;
   logic [15:0] cmd;
   logic        cmd_rdy, frm_err;

   int n_checks = 0;
   int n_err    = 0;
   int frm_cnt  = 0;

   // reference model: what the transmit buffer and command register should hold
   logic [15:0] m_tx_buf;
   logic [15:0] m_cmd;

   spi_serf dut (
      .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
      .wrt(wrt), .tx_data(tx_data), .cmd(cmd), .cmd_rdy(cmd_rdy),
      .clr_cmd_rdy(clr_cmd_rdy), .frm_err(frm_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (frm_err) frm_cnt <= frm_cnt + 1;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_err);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_wrt(input logic [15:0] v);
      @(negedge clk);
      wrt = 1'b1; tx_data = v;
      @(negedge clk);
      wrt = 1'b0;
      m_tx_buf = v;
   endtask

   task automatic frame_start(output logic rdy_mid);
      @(negedge clk);
      SS_n = 1'b0;
      repeat (16) @(negedge clk);
      rdy_mid = cmd_rdy;
   endtask

   // each bit: leading fall (MOSI changes), 16 clk, rise, sample MISO 2 clk later
   task automatic frame_bits(input logic [15:0] word, input int n, input int wrt_at,
                             input logic [15:0] wrt_val, output logic [15:0] resp);
      logic [15:0] sh;
      sh   = word;
      resp = 16'h0000;
      for (int i = 0; i < n; i++) begin
         SCLK = 1'b0;
         MOSI = sh[15];
         sh   = sh << 1;
         if (i == wrt_at) begin
            repeat (8) @(negedge clk);
            wrt = 1'b1; tx_data = wrt_val;
            @(negedge clk);
            wrt = 1'b0;
            repeat (7) @(negedge clk);
         end else begin
            repeat (16) @(negedge clk);
         end
         SCLK = 1'b1;
         repeat (2) @(negedge clk);
         resp = {resp[14:0], MISO};
         repeat (14) @(negedge clk);
      end
   endtask

   task automatic frame_end(output int rdy_first, output int rdy_cycles, output int err_pulses);
      repeat (16) @(negedge clk);
      SS_n = 1'b1;
      MOSI = 1'b0;
      rdy_first = 0; rdy_cycles = 0; err_pulses = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (cmd_rdy) begin
            rdy_cycles++;
            if (rdy_first == 0) rdy_first = c;
         end
         if (frm_err) err_pulses++;
      end
   endtask

   task automatic run_frame(input logic [15:0] word, input int n, input int wrt_at,
                            input logic [15:0] wrt_val, input logic clr_hold);
      logic        rdy_mid;
      logic [15:0] resp, frame_buf;
      int          first, cyc, errs;
      frame_buf = m_tx_buf;
      frame_start(rdy_mid);
      check("rdy_cleared_by_ss_fall", {15'd0, rdy_mid}, 16'd0);
      frame_bits(word, n, wrt_at, wrt_val, resp);
      if (wrt_at >= 0 && wrt_at < n) m_tx_buf = wrt_val;
      clr_cmd_rdy = clr_hold;
      frame_end(first, cyc, errs);
      clr_cmd_rdy = 1'b0;
      check("miso_resp", resp, frame_buf >> (16 - n));
      check("frm_err_pulses", 16'(errs), (n == 16) ? 16'd0 : 16'd1);
      if (n == 16) begin
         m_cmd = word;
         check("rdy_latency_le5", {15'd0, (first >= 1 && first <= 5)}, 16'd1);
         check("rdy_cycles", 16'(cyc), clr_hold ? 16'd1 : 16'(9 - first));
      end else begin
         check("rdy_stays_low", 16'(cyc), 16'd0);
      end
      check("cmd", cmd, m_cmd);
   endtask

   initial begin
      int          snap, n, wat;
      logic        dummy;
      logic [15:0] resp;

      rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
      wrt = 1'b0; tx_data = 16'h0000; clr_cmd_rdy = 1'b0;
      m_tx_buf = 16'h0000; m_cmd = 16'h0000;
      repeat (4) @(negedge clk);
      check("reset_miso", {15'd0, MISO}, 16'd0);
      check("reset_cmd", cmd, 16'h0000);
      check("reset_cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
      check("reset_frm_err", {15'd0, frm_err}, 16'd0);
      rst = 1'b0;
      repeat (6) @(negedge clk);

      // paired-transaction example, then consumer acknowledge
      do_wrt(16'h3C5A);
      run_frame(16'hA5C3, 16, -1, 16'h0, 1'b0);
      clr_cmd_rdy = 1'b1;
      @(negedge clk);
      clr_cmd_rdy = 1'b0;
      check("clr_cmd_rdy", {15'd0, cmd_rdy}, 16'd0);

      // back-to-back without acknowledge
      run_frame(16'h0001, 16, -1, 16'h0, 1'b0);
      run_frame(16'h8000, 16, -1, 16'h0, 1'b0);

      // short and empty frames
      run_frame(16'h5555, 8, -1, 16'h0, 1'b0);
      run_frame(16'h7777, 0, -1, 16'h0, 1'b0);

      // mid-frame wrt affects only the next frame
      do_wrt(16'h1234);
      run_frame(16'(($urandom)), 16, 7, 16'hFFFF, 1'b0);
      run_frame(16'h0F0F, 16, -1, 16'h0, 1'b0);

      // acknowledge held across the set cycle
      run_frame(16'(($urandom)), 16, -1, 16'h0, 1'b1);

      // reset after 5 bits aborts the frame silently
      do_wrt(16'hC3C3);
      frame_start(dummy);
      frame_bits(16'h1357, 5, -1, 16'h0, resp);
      snap = frm_cnt;
      rst = 1'b1;
      @(negedge clk);
      check("abort_miso", {15'd0, MISO}, 16'd0);
      check("abort_cmd_rdy", {15'd0, cmd_rdy}, 16'd0);
      rst = 1'b0;
      m_tx_buf = 16'h0000; m_cmd = 16'h0000;
      repeat (20) @(negedge clk);
      check("abort_miso_after", {15'd0, MISO}, 16'd0);
      SS_n = 1'b1;
      repeat (10) @(negedge clk);
      check("abort_no_frm_err", 16'(frm_cnt - snap), 16'd0);
      check("abort_cmd", cmd, 16'h0000);
      do_wrt(16'h2468);
      run_frame(16'hBEEF, 16, -1, 16'h0, 1'b0);

      // randomized frames
      for (int k = 0; k < 6; k++) begin
         do_wrt(16'($urandom));
         n   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
         wat = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 15)) : -1;
         run_frame(16'($urandom), n, wat, 16'($urandom), 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
